instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch_skid_buffer.sv | 48 ++++
 rtl/instruction_fetch.sv | 188 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// default sequential PC step and the bubble instruction.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    localparam int          FETCH_PC_STEP         = 4;
    localparam logic [31:0] FETCH_NOP_INSTRUCTION = 32'h0000_0000;

    // DISCARD keeps the original read alive until memory answers it.
    function automatic logic fetch_request_active(input fetch_state_e state);
        fetch_request_active = (state == ST_FETCH) || (state == ST_DISCARD);
    endfunction

endpackage

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry {instruction, pc} holding register used when decode stalls
// while a read is completing.
module fetch_skid_buffer #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDR_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         unload,
    input  logic                         clear,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
    input  logic [ADDR_WIDTH-1:0]        pc_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic                         full
);

    logic [INSTRUCTION_WIDTH-1:0] instruction_r;
    logic [ADDR_WIDTH-1:0]        pc_r;
    logic                         full_r;

    // Buffer storage: clear beats load, load beats unload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction_r <= {INSTRUCTION_WIDTH{1'b0}};
            pc_r          <= {ADDR_WIDTH{1'b0}};
            full_r        <= 1'b0;
        end else if (clear) begin
            instruction_r <= {INSTRUCTION_WIDTH{1'b0}};
            pc_r          <= {ADDR_WIDTH{1'b0}};
            full_r        <= 1'b0;
        end else if (load) begin
            instruction_r <= instruction_in;
            pc_r          <= pc_in;
            full_r        <= 1'b1;
        end else if (unload) begin
            full_r        <= 1'b0;
        end else begin
            full_r        <= full_r;
        end
    end

    assign instruction = instruction_r;
    assign pc          = pc_r;
    assign full        = full_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and hands
// registered instructions to decode, with stall skid and redirect flushing.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter int                           ADDR_WIDTH        = 32,
    parameter logic [ADDR_WIDTH-1:0]        PC_RESET          = {ADDR_WIDTH{1'b0}},
    parameter int                           PC_STEP           = FETCH_PC_STEP,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION   = INSTRUCTION_WIDTH'(FETCH_NOP_INSTRUCTION)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_in,
    input  logic                         redirect_in,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc_in,
    output logic                         imem_req_out,
    output logic [ADDR_WIDTH-1:0]        imem_addr_out,
    input  logic                         imem_ack_in,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [ADDR_WIDTH-1:0]        pc_out,
    output logic                         inst_valid_out
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    fetch_state_e                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]        pc_r, pc_s;
    logic [ADDR_WIDTH-1:0]        addr_r, addr_s;
    logic                         req_r, req_s;
    logic [INSTRUCTION_WIDTH-1:0] instr_r, instr_s;
    logic [ADDR_WIDTH-1:0]        pc_out_r, pc_out_s;
    logic                         valid_r, valid_s;

    logic                         out_free_s;
    logic [ADDR_WIDTH-1:0]        pc_inc_s;
    logic [ADDR_WIDTH-1:0]        target_s;
    logic                         skid_load_s, skid_unload_s, skid_clear_s;
    logic [INSTRUCTION_WIDTH-1:0] skid_instr_s;
    logic [ADDR_WIDTH-1:0]        skid_pc_s;
    logic                         skid_full_s;

    fetch_skid_buffer #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .ADDR_WIDTH        (ADDR_WIDTH)
    ) u_skid (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (skid_load_s),
        .unload         (skid_unload_s),
        .clear          (skid_clear_s),
        .instruction_in (imem_data_in),
        .pc_in          (pc_inc_s),
        .instruction    (skid_instr_s),
        .pc             (skid_pc_s),
        .full           (skid_full_s)
    );

    // Next-state, PC, output-register and memory-interface decisions.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        instr_s       = instr_r;
        pc_out_s      = pc_out_r;
        valid_s       = valid_r;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        skid_clear_s  = 1'b0;
        out_free_s    = !valid_r || !stall_in;
        pc_inc_s      = pc_r + ADDR_WIDTH'(PC_STEP);
        target_s      = redirect_pc_in & ALIGN_MASK;

        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
                if (redirect_in) begin
                    pc_s         = target_s;
                    valid_s      = 1'b0;
                    instr_s      = NOP_INSTRUCTION;
                    skid_clear_s = 1'b1;
                end else begin
                    pc_s = pc_r;
                end
            end
            ST_FETCH: begin
                if (redirect_in) begin
                    // An ack this cycle retires the old read, so no discard is needed.
                    pc_s         = target_s;
                    valid_s      = 1'b0;
                    instr_s      = NOP_INSTRUCTION;
                    skid_clear_s = 1'b1;
                    if (imem_ack_in) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end else if (imem_ack_in) begin
                    pc_s = pc_inc_s;
                    if (out_free_s) begin
                        instr_s  = imem_data_in;
                        pc_out_s = pc_inc_s;
                        valid_s  = 1'b1;
                    end else begin
                        skid_load_s = 1'b1;
                        state_s     = ST_HOLD;
                    end
                end else if (out_free_s) begin
                    valid_s = 1'b0;
                    instr_s = NOP_INSTRUCTION;
                end else begin
                    valid_s = valid_r;
                end
            end
            ST_HOLD: begin
                if (redirect_in) begin
                    pc_s         = target_s;
                    valid_s      = 1'b0;
                    instr_s      = NOP_INSTRUCTION;
                    skid_clear_s = 1'b1;
                    state_s      = ST_FETCH;
                end else if (!stall_in) begin
                    skid_unload_s = 1'b1;
                    instr_s       = skid_instr_s;
                    pc_out_s      = skid_pc_s;
                    valid_s       = skid_full_s;
                    state_s       = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (redirect_in) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_ack_in) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                valid_s      = 1'b0;
                instr_s      = NOP_INSTRUCTION;
                skid_clear_s = 1'b1;
            end
        endcase

        // Address only follows the PC in FETCH; DISCARD must keep the old one.
        req_s = fetch_request_active(state_s);
        if (state_s == ST_FETCH) begin
            addr_s = pc_s;
        end else begin
            addr_s = addr_r;
        end
    end

    // State, PC, memory interface and decode-facing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= PC_RESET;
            addr_r   <= PC_RESET;
            req_r    <= 1'b0;
            instr_r  <= NOP_INSTRUCTION;
            pc_out_r <= {ADDR_WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            addr_r   <= addr_s;
            req_r    <= req_s;
            instr_r  <= instr_s;
            pc_out_r <= pc_out_s;
            valid_r  <= valid_s;
        end
    end

    assign imem_req_out    = req_r;
    assign imem_addr_out   = addr_r;
    assign instruction_out = instr_r;
    assign pc_out          = pc_out_r;
    assign inst_valid_out  = valid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a negedge memory model returns the
// address as data after a programmable number of wait cycles.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in = 1'b0;
    logic [31:0] imem_data_in = 32'h0;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        inst_valid_out;

    int n_cmp = 0;
    int n_err = 0;
    int mem_lat = 0;
    int wait_cnt = 0;
    bit mem_en = 1'b1;

    instruction_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_in        (stall_in),
        .redirect_in     (redirect_in),
        .redirect_pc_in  (redirect_pc_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_ack_in     (imem_ack_in),
        .imem_data_in    (imem_data_in),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .inst_valid_out  (inst_valid_out)
    );

    always #5 clk = ~clk;

    // Memory model: acks after mem_lat wait cycles, data equals address.
    always @(negedge clk) begin
        if (mem_en) begin
            if (imem_req_out === 1'b1) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ack_in  = 1'b1;
                    imem_data_in = imem_addr_out;
                    wait_cnt     = 0;
                end else begin
                    imem_ack_in = 1'b0;
                    wait_cnt    = wait_cnt + 1;
                end
            end else begin
                imem_ack_in = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_in = 1'b0;
        redirect_in = 1'b0;
        mem_lat = 0;
        mem_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        repeat (2) cyc();
        n_cmp++; if (imem_req_out !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req_out); end
        n_cmp++; if (imem_addr_out !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr_out); end
        n_cmp++; if (instruction_out !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0", instruction_out); end
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL rst_pc_out: got %h want 0", pc_out); end
        n_cmp++; if (inst_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", inst_valid_out); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req_out !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req_out); end
        cyc();
        n_cmp++; if (imem_req_out !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req_out); end
        n_cmp++; if (imem_addr_out !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 0", imem_addr_out); end
    endtask

    task automatic test_sequential();
        do_reset();
        cyc();
        n_cmp++; if (inst_valid_out !== 1'b0) begin n_err++; $display("FAIL seq_first_valid: got %b want 0", inst_valid_out); end
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_cmp++; if (instruction_out !== 32'(4*k)) begin n_err++; $display("FAIL seq_instr[%0d]: got %h want %h", k, instruction_out, 32'(4*k)); end
            n_cmp++; if (pc_out !== 32'(4*k+4)) begin n_err++; $display("FAIL seq_pc_out[%0d]: got %h want %h", k, pc_out, 32'(4*k+4)); end
            n_cmp++; if (inst_valid_out !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", k, inst_valid_out); end
            n_cmp++; if (imem_addr_out !== 32'(4*k+4)) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", k, imem_addr_out, 32'(4*k+4)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        cyc();
        cyc();
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++; if (imem_req_out !== 1'b0) begin n_err++; $display("FAIL hold_req[%0d]: got %b want 0", k, imem_req_out); end
            n_cmp++; if (instruction_out !== 32'h0 || pc_out !== 32'h4) begin n_err++; $display("FAIL hold_out[%0d]: got %h/%h want 0/4", k, instruction_out, pc_out); end
            n_cmp++; if (inst_valid_out !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", k, inst_valid_out); end
        end
        stall_in = 1'b0;
        cyc();
        n_cmp++; if (instruction_out !== 32'h4 || pc_out !== 32'h8) begin n_err++; $display("FAIL skid_out: got %h/%h want 4/8", instruction_out, pc_out); end
        n_cmp++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h8) begin n_err++; $display("FAIL resume_req: got %b/%h want 1/8", imem_req_out, imem_addr_out); end
        cyc();
        n_cmp++; if (instruction_out !== 32'h8 || pc_out !== 32'hC || inst_valid_out !== 1'b1) begin n_err++; $display("FAIL after_skid: got %h/%h/%b want 8/c/1", instruction_out, pc_out, inst_valid_out); end
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        cyc();
        cyc();
        cyc();
        mem_lat = 2;
        redirect_in = 1'b1;
        redirect_pc_in = 32'h100;
        cyc();
        redirect_in = 1'b0;
        n_cmp++; if (inst_valid_out !== 1'b0 || instruction_out !== 32'h0) begin n_err++; $display("FAIL disc_out: got %b/%h want 0/0", inst_valid_out, instruction_out); end
        n_cmp++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h8) begin n_err++; $display("FAIL disc_addr0: got %b/%h want 1/8", imem_req_out, imem_addr_out); end
        cyc();
        n_cmp++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h8) begin n_err++; $display("FAIL disc_addr1: got %b/%h want 1/8", imem_req_out, imem_addr_out); end
        n_cmp++; if (inst_valid_out !== 1'b0) begin n_err++; $display("FAIL disc_valid1: got %b want 0", inst_valid_out); end
        cyc();
        mem_lat = 0;
        n_cmp++; if (imem_addr_out !== 32'h100 || inst_valid_out !== 1'b0) begin n_err++; $display("FAIL disc_target: got %h/%b want 100/0", imem_addr_out, inst_valid_out); end
        cyc();
        n_cmp++; if (instruction_out !== 32'h100 || pc_out !== 32'h104 || inst_valid_out !== 1'b1) begin n_err++; $display("FAIL disc_first: got %h/%h/%b want 100/104/1", instruction_out, pc_out, inst_valid_out); end
    endtask

    task automatic test_redirect_ack_stall();
        do_reset();
        cyc();
        cyc();
        stall_in = 1'b1;
        redirect_in = 1'b1;
        redirect_pc_in = 32'h200;
        cyc();
        redirect_in = 1'b0;
        n_cmp++; if (inst_valid_out !== 1'b0 || instruction_out !== 32'h0) begin n_err++; $display("FAIL ras_out: got %b/%h want 0/0", inst_valid_out, instruction_out); end
        n_cmp++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h200) begin n_err++; $display("FAIL ras_addr: got %b/%h want 1/200", imem_req_out, imem_addr_out); end
        cyc();
        n_cmp++; if (instruction_out !== 32'h200 || pc_out !== 32'h204 || inst_valid_out !== 1'b1) begin n_err++; $display("FAIL ras_stall_fill: got %h/%h/%b want 200/204/1", instruction_out, pc_out, inst_valid_out); end
        cyc();
        n_cmp++; if (imem_req_out !== 1'b0 || instruction_out !== 32'h200) begin n_err++; $display("FAIL ras_hold: got %b/%h want 0/200", imem_req_out, instruction_out); end
        redirect_in = 1'b1;
        redirect_pc_in = 32'h300;
        cyc();
        redirect_in = 1'b0;
        stall_in = 1'b0;
        n_cmp++; if (inst_valid_out !== 1'b0 || imem_addr_out !== 32'h300 || imem_req_out !== 1'b1) begin n_err++; $display("FAIL hold_redirect: got %b/%h/%b want 0/300/1", inst_valid_out, imem_addr_out, imem_req_out); end
        cyc();
        n_cmp++; if (instruction_out !== 32'h300 || pc_out !== 32'h304 || inst_valid_out !== 1'b1) begin n_err++; $display("FAIL hold_redirect_out: got %h/%h/%b want 300/304/1", instruction_out, pc_out, inst_valid_out); end
    endtask

    task automatic test_align_wrap();
        do_reset();
        cyc();
        redirect_in = 1'b1;
        redirect_pc_in = 32'h103;
        cyc();
        redirect_in = 1'b0;
        n_cmp++; if (imem_addr_out !== 32'h100 || inst_valid_out !== 1'b0) begin n_err++; $display("FAIL align_addr: got %h/%b want 100/0", imem_addr_out, inst_valid_out); end
        cyc();
        n_cmp++; if (instruction_out !== 32'h100 || pc_out !== 32'h104) begin n_err++; $display("FAIL align_out: got %h/%h want 100/104", instruction_out, pc_out); end
        redirect_in = 1'b1;
        redirect_pc_in = 32'hFFFF_FFFC;
        cyc();
        redirect_in = 1'b0;
        n_cmp++; if (imem_addr_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr_out); end
        cyc();
        n_cmp++; if (instruction_out !== 32'hFFFF_FFFC || pc_out !== 32'h0 || imem_addr_out !== 32'h0) begin n_err++; $display("FAIL wrap: got %h/%h/%h want fffffffc/0/0", instruction_out, pc_out, imem_addr_out); end
        cyc();
        n_cmp++; if (instruction_out !== 32'h0 || pc_out !== 32'h4 || inst_valid_out !== 1'b1) begin n_err++; $display("FAIL wrap_next: got %h/%h/%b want 0/4/1", instruction_out, pc_out, inst_valid_out); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cyc();
        cyc();
        n_cmp++; if (inst_valid_out !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", inst_valid_out); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (imem_req_out !== 1'b0 || imem_addr_out !== 32'h0) begin n_err++; $display("FAIL mid_rst_mem: got %b/%h want 0/0", imem_req_out, imem_addr_out); end
        n_cmp++; if (inst_valid_out !== 1'b0 || instruction_out !== 32'h0 || pc_out !== 32'h0) begin n_err++; $display("FAIL mid_rst_out: got %b/%h/%h want 0/0/0", inst_valid_out, instruction_out, pc_out); end
        mem_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_ack_in = 1'b1;
        imem_data_in = 32'hDEAD_BEEF;
        cyc();
        imem_ack_in = 1'b0;
        mem_lat = 0;
        mem_en = 1'b1;
        n_cmp++; if (inst_valid_out !== 1'b0 || instruction_out !== 32'h0) begin n_err++; $display("FAIL late_ack: got %b/%h want 0/0", inst_valid_out, instruction_out); end
        n_cmp++; if (imem_req_out !== 1'b1 || imem_addr_out !== 32'h0) begin n_err++; $display("FAIL restart_addr: got %b/%h want 1/0", imem_req_out, imem_addr_out); end
        cyc();
        n_cmp++; if (instruction_out !== 32'h0 || pc_out !== 32'h4 || inst_valid_out !== 1'b1) begin n_err++; $display("FAIL restart_out: got %h/%h/%b want 0/4/1", instruction_out, pc_out, inst_valid_out); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_outstanding();
        test_redirect_ack_stall();
        test_align_wrap();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
